// File: rtl/acc_unit.sv
// acc_unit: nibble-serial accumulator with LOAD/ADD/SUB/CLR commands and C/Z/N/V flags.
// Optional feature macro: ACC_UNIT_SUB_EN enables the SUB command (op 10);
// without it, op 10 is accepted as a no-op that still pulses out_valid.
module acc_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc,
    output logic             out_valid,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             busy
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             fc_q, fc_d, fz_q, fz_d, fn_q, fn_d, fv_q, fv_d;
    logic [CW+1:0]    base;
    logic [4:0]       sum;
    // Current slice: the effective operand is already inverted for SUB, so one adder serves both.
    always_comb begin
        base = {cnt_q, 2'b00};
        sum  = {1'b0, acc_q[base +: 4]} + {1'b0, opnd_q[base +: 4]} + {4'b0, carry_q};
    end
    // Next-state, datapath and flag update; acc only changes on a commit.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        fc_d    = fc_q;
        fz_d    = fz_q;
        fn_d    = fn_q;
        fv_d    = fv_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = DONE;
                    if (op == OP_LOAD) begin
                        acc_d = operand;
                        fz_d  = (operand == '0);
                        fn_d  = operand[WIDTH-1];
                        fv_d  = 1'b0;
                    end else if (op == OP_CLR) begin
                        acc_d = '0;
                        fc_d  = 1'b0;
                        fz_d  = 1'b1;
                        fn_d  = 1'b0;
                        fv_d  = 1'b0;
                    end else if (op == OP_ADD) begin
                        state_d = CALC;
                        opnd_d  = operand;
                        carry_d = 1'b0;
                        cnt_d   = '0;
                        res_d   = '0;
                    end
`ifdef ACC_UNIT_SUB_EN
                    else if (op == OP_SUB) begin
                        state_d = CALC;
                        opnd_d  = ~operand;
                        carry_d = 1'b1;
                        cnt_d   = '0;
                        res_d   = '0;
                    end
`endif
                end
            end
            CALC: begin
                res_d[base +: 4] = sum[3:0];
                carry_d          = sum[4];
                cnt_d            = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    acc_d   = res_d;
                    fc_d    = sum[4];
                    fz_d    = (res_d == '0);
                    fn_d    = res_d[WIDTH-1];
                    fv_d    = (acc_q[WIDTH-1] == opnd_q[WIDTH-1]) && (res_d[WIDTH-1] != acc_q[WIDTH-1]);
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // State registers; reset discards any in-flight slice work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            fc_q    <= 1'b0;
            fz_q    <= 1'b0;
            fn_q    <= 1'b0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            fc_q    <= fc_d;
            fz_q    <= fz_d;
            fn_q    <= fn_d;
            fv_q    <= fv_d;
        end
    end
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign acc       = acc_q;
    assign flag_c    = fc_q;
    assign flag_z    = fz_q;
    assign flag_n    = fn_q;
    assign flag_v    = fv_q;
    logic unused_sub;
    assign unused_sub = (OP_SUB == 2'b10);
endmodule

// File: tb/tb_acc_unit.sv
// tb_acc_unit: directed checks of acc_unit (WIDTH=8) with immediate assertions.
module tb_acc_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] op = 2'b00;
    logic [7:0] operand = 8'h00;
    logic [7:0] acc;
    logic       out_valid, flag_c, flag_z, flag_n, flag_v, busy;
    int         checks = 0;
    int         errors = 0;

    acc_unit #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .operand(operand), .acc(acc), .out_valid(out_valid),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flags packed as {c,z,n,v}.
    task automatic chk_flags(input string tag, input logic [3:0] exp);
        chk(tag, {4'b0, flag_c, flag_z, flag_n, flag_v}, {4'b0, exp});
    endtask

    // Issue one command from IDLE, then check latency, acc hold and return to IDLE.
    task automatic run(input string tag, input logic [1:0] o, input logic [7:0] d,
                       input int lat, input logic [7:0] old_acc);
        chk({tag, "_ready"}, {7'b0, in_ready}, 8'd1);
        in_valid = 1'b1;
        op       = o;
        operand  = d;
        tick();
        in_valid = 1'b0;
        op       = 2'b00;
        operand  = ~d;
        for (int k = 1; k <= lat; k++) begin
            if (k < lat) begin
                chk({tag, "_calc_ov"}, {7'b0, out_valid}, 8'd0);
                chk({tag, "_calc_acc"}, acc, old_acc);
                chk({tag, "_calc_rdy"}, {7'b0, in_ready}, 8'd0);
                tick();
            end else begin
                chk({tag, "_ov"}, {7'b0, out_valid}, 8'd1);
                chk({tag, "_busy"}, {7'b0, busy}, 8'd1);
            end
        end
        tick();
        chk({tag, "_ov_end"}, {7'b0, out_valid}, 8'd0);
        chk({tag, "_idle"}, {7'b0, in_ready}, 8'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_acc", acc, 8'h00);
        chk_flags("rst_flags", 4'b0000);
        chk("rst_ov", {7'b0, out_valid}, 8'd0);
        chk("rst_busy", {7'b0, busy}, 8'd0);

        run("clr", 2'b11, 8'h5A, 1, 8'h00);
        chk("clr_acc", acc, 8'h00);
        chk_flags("clr_flags", 4'b0100);

        run("ld7f", 2'b00, 8'h7F, 1, 8'h00);
        chk("ld7f_acc", acc, 8'h7F);
        chk_flags("ld7f_flags", 4'b0000);

        run("add01", 2'b01, 8'h01, 3, 8'h7F);
        chk("add01_acc", acc, 8'h80);
        chk_flags("add01_flags", 4'b0011);

        run("ldff", 2'b00, 8'hFF, 1, 8'h80);
        chk("ldff_acc", acc, 8'hFF);
        chk_flags("ldff_flags", 4'b0010);

        run("wrap", 2'b01, 8'h01, 3, 8'hFF);
        chk("wrap_acc", acc, 8'h00);
        chk_flags("wrap_flags", 4'b1100);

        run("ld05", 2'b00, 8'h05, 1, 8'h00);
        chk("ld05_acc", acc, 8'h05);
        chk_flags("ld05_flags", 4'b1000);

`ifdef ACC_UNIT_SUB_EN
        run("sub07", 2'b10, 8'h07, 3, 8'h05);
        chk("sub07_acc", acc, 8'hFE);
        chk_flags("sub07_flags", 4'b0010);
        run("ld80", 2'b00, 8'h80, 1, 8'hFE);
        chk("ld80_acc", acc, 8'h80);
        chk_flags("ld80_flags", 4'b0010);
        run("sub01", 2'b10, 8'h01, 3, 8'h80);
        chk("sub01_acc", acc, 8'h7F);
        chk_flags("sub01_flags", 4'b1001);
`else
        run("subnop", 2'b10, 8'h07, 1, 8'h05);
        chk("subnop_acc", acc, 8'h05);
        chk_flags("subnop_flags", 4'b1000);
`endif

        run("clr2", 2'b11, 8'h00, 1, acc);
        chk("clr2_acc", acc, 8'h00);
        in_valid = 1'b1;
        op       = 2'b01;
        operand  = 8'h01;
        for (int i = 0; i < 12; i++) begin
            tick();
            case (i % 4)
                0, 1: begin
                    chk("b2b_rdy_calc", {7'b0, in_ready}, 8'd0);
                    chk("b2b_ov_calc", {7'b0, out_valid}, 8'd0);
                    chk("b2b_acc_hold", acc, 8'(i / 4));
                end
                2: begin
                    chk("b2b_rdy_done", {7'b0, in_ready}, 8'd0);
                    chk("b2b_ov_done", {7'b0, out_valid}, 8'd1);
                    chk("b2b_acc_inc", acc, 8'(i / 4 + 1));
                end
                default: begin
                    chk("b2b_rdy_idle", {7'b0, in_ready}, 8'd1);
                    chk("b2b_ov_idle", {7'b0, out_valid}, 8'd0);
                end
            endcase
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_stop", {7'b0, in_ready}, 8'd1);
        chk("b2b_final", acc, 8'h03);

        run("ld22", 2'b00, 8'h22, 1, 8'h03);
        chk("ld22_acc", acc, 8'h22);
        in_valid = 1'b1;
        op       = 2'b01;
        operand  = 8'h11;
        tick();
        in_valid = 1'b0;
        tick();
        chk("rstmid_busy", {7'b0, busy}, 8'd1);
        chk("rstmid_hold", acc, 8'h22);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_acc", acc, 8'h00);
        chk_flags("rstmid_flags", 4'b0000);
        chk("rstmid_ov", {7'b0, out_valid}, 8'd0);
        chk("rstmid_rdy", {7'b0, in_ready}, 8'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstmid_no_ov", {7'b0, out_valid}, 8'd0);
            chk("rstmid_acc_stay", acc, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
